// File: rtl/canny_pkg.sv
// Shared constants for the Canny edge path: direction codes from the Sobel stage
// and tap indices of the row-major 3x3 window.
package canny_pkg;

  localparam int DIR_HORZ    = 1;
  localparam int DIR_DIAG_TL = 2;
  localparam int DIR_VERT    = 3;
  localparam int DIR_DIAG_TR = 4;

  localparam int TAP_TL = 0;
  localparam int TAP_T  = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_L  = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_R  = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_B  = 7;
  localparam int TAP_BR = 8;

endpackage

// File: rtl/nms_pos_cnt.sv
// Frame position tracker for the NMS stage: follows col/row of each accepted beat,
// resyncs on start-of-frame and flags border and last-pixel beats.
module nms_pos_cnt #(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int BORDER = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic accept,
  input  logic sof,
  output logic border,
  output logic last
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0] col, cur_col;
  logic [ROW_W-1:0] row, cur_row;
  logic             col_end, row_end;

  // A start-of-frame beat is itself pixel (0,0), so it overrides the stored position.
  always_comb begin
    cur_col = sof ? '0 : col;
    cur_row = sof ? '0 : row;
    col_end = (cur_col == COL_W'(IMG_W - 1));
    row_end = (cur_row == ROW_W'(IMG_H - 1));
    border  = (int'(cur_col) < BORDER) || (int'(cur_col) >= IMG_W - BORDER) ||
              (int'(cur_row) < BORDER) || (int'(cur_row) >= IMG_H - BORDER);
    last    = col_end && row_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

endmodule

// File: rtl/nms_stream.sv
// Streaming non-maximum suppression for the Canny path: two-stage valid/ready pipe that
// thins edges along the gradient direction, blanks the image border and counts bad codes.
module nms_stream
  import canny_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DIR_W    = 8,
  parameter int IMG_W    = 512,
  parameter int IMG_H    = 512,
  parameter int BORDER   = 1,
  parameter int TIE_MODE = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9*DATA_W-1:0] s_mag,
  input  logic [DIR_W-1:0]  s_dir,
  input  logic              s_sof,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              bypass,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  dir_err_cnt
);

  logic              adv, accept;
  logic              border_flag, last_flag;
  logic [DATA_W-1:0] centre, n_a, n_b;
  logic              illegal, keep;

  logic              v1, keep1, border1, last1, illegal1;
  logic [DATA_W-1:0] centre1, out_val;

  assign adv     = !m_valid || m_ready;
  assign s_ready = adv;
  assign accept  = s_valid && adv;

  nms_pos_cnt #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .BORDER (BORDER)
  ) u_pos (
    .clk    (clk),
    .rst_n  (rst_n),
    .accept (accept),
    .sof    (s_sof),
    .border (border_flag),
    .last   (last_flag)
  );

  // Neighbour pair lies along the gradient direction through the centre pixel.
  always_comb begin
    centre  = s_mag[TAP_C*DATA_W +: DATA_W];
    n_a     = '0;
    n_b     = '0;
    illegal = 1'b0;
    case (int'(s_dir))
      DIR_HORZ: begin
        n_a = s_mag[TAP_L*DATA_W +: DATA_W];
        n_b = s_mag[TAP_R*DATA_W +: DATA_W];
      end
      DIR_DIAG_TL: begin
        n_a = s_mag[TAP_TL*DATA_W +: DATA_W];
        n_b = s_mag[TAP_BR*DATA_W +: DATA_W];
      end
      DIR_VERT: begin
        n_a = s_mag[TAP_T*DATA_W +: DATA_W];
        n_b = s_mag[TAP_B*DATA_W +: DATA_W];
      end
      DIR_DIAG_TR: begin
        n_a = s_mag[TAP_TR*DATA_W +: DATA_W];
        n_b = s_mag[TAP_BL*DATA_W +: DATA_W];
      end
      default: illegal = 1'b1;
    endcase
    keep = (centre >= n_a) && ((TIE_MODE == 1) ? (centre > n_b) : (centre >= n_b));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      keep1    <= 1'b0;
      centre1  <= '0;
      border1  <= 1'b0;
      last1    <= 1'b0;
      illegal1 <= 1'b0;
    end else if (adv) begin
      v1       <= s_valid;
      keep1    <= keep;
      centre1  <= centre;
      border1  <= border_flag;
      last1    <= last_flag;
      illegal1 <= illegal;
    end
  end

  // Bypass skips the thinning decision only; border blanking always wins.
  always_comb begin
    out_val = centre1;
    if (border1 || (!bypass && (illegal1 || !keep1)))
      out_val = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (adv) begin
      m_valid <= v1;
      m_data  <= out_val;
      m_last  <= v1 && last1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dir_err_cnt <= '0;
    else if (accept && illegal && (dir_err_cnt != {CNT_W{1'b1}}))
      dir_err_cnt <= dir_err_cnt + 1'b1;
  end

endmodule

// File: tb/tb_nms_stream.sv
// Bench for nms_stream: two instances (tie modes 0 and 1) on an 8x4 frame, checked every
// cycle against a position/direction model plus hand-computed literal beats.
module tb_nms_stream;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int FRAME = W * H;
  localparam int CMAX  = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [71:0] s_mag;
  logic [7:0]  s_dir;
  logic        s_sof, s_valid, bypass;
  logic        m_ready = 1'b1;
  logic        s_ready0, s_ready1, m_last0, m_last1, m_valid0, m_valid1;
  logic [7:0]  m_data0, m_data1;
  logic [2:0]  cnt0, cnt1;

  always #5 clk = ~clk;

  nms_stream #(.DATA_W(8), .DIR_W(8), .IMG_W(W), .IMG_H(H), .BORDER(1), .TIE_MODE(0), .CNT_W(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_mag(s_mag), .s_dir(s_dir), .s_sof(s_sof), .s_valid(s_valid),
    .s_ready(s_ready0), .bypass(bypass), .m_data(m_data0), .m_last(m_last0), .m_valid(m_valid0),
    .m_ready(m_ready), .dir_err_cnt(cnt0));

  nms_stream #(.DATA_W(8), .DIR_W(8), .IMG_W(W), .IMG_H(H), .BORDER(1), .TIE_MODE(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_mag(s_mag), .s_dir(s_dir), .s_sof(s_sof), .s_valid(s_valid),
    .s_ready(s_ready1), .bypass(bypass), .m_data(m_data1), .m_last(m_last1), .m_valid(m_valid1),
    .m_ready(m_ready), .dir_err_cnt(cnt1));

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int tapOf(input logic [71:0] w, input int r, input int c);
    return int'(w[(r*3 + c)*8 +: 8]);
  endfunction

  // Neighbours are the two pixels one step either side of the centre along the gradient.
  function automatic logic [7:0] nmsModel(input logic [71:0] w, input int dir, input bit byp,
                                          input bit brd, input int tie);
    int dr, dc, c, a, b;
    bit legal, keep;
    legal = (dir >= 1) && (dir <= 4);
    dr = 0; dc = 0;
    case (dir)
      1: begin dr = 0; dc = 1;  end
      2: begin dr = 1; dc = 1;  end
      3: begin dr = 1; dc = 0;  end
      4: begin dr = 1; dc = -1; end
      default: ;
    endcase
    c = tapOf(w, 1, 1);
    a = tapOf(w, 1 - dr, 1 - dc);
    b = tapOf(w, 1 + dr, 1 + dc);
    keep = (tie == 1) ? (c >= a && c > b) : (c >= a && c >= b);
    if (brd) return 8'd0;
    if (byp) return 8'(c);
    if (!legal || !keep) return 8'd0;
    return 8'(c);
  endfunction

  typedef struct { logic [7:0] d0; logic [7:0] d1; logic last; } beat_t;
  beat_t exp_q[$];
  int model_pos = 0;
  int model_cnt = 0;
  int last_total = 0;
  int nz_total = 0;
  int out_total = 0;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_d0 = '0, prev_d1 = '0;

  // Everything observed at a falling edge describes what the next rising edge will do.
  always @(negedge clk) begin
    beat_t e;
    int col, row, dirv;
    bit brd;
    if (!rst_n) begin
      exp_q.delete();
      model_pos = 0;
      model_cnt = 0;
      prev_v = 1'b0;
      checkOutput("reset_valid", m_valid0, 0);
    end else begin
      checkOutput("dir_err_cnt0", cnt0, model_cnt);
      checkOutput("dir_err_cnt1", cnt1, model_cnt);
      checkOutput("valid_pair", m_valid1, m_valid0);
      checkOutput("ready_pair", s_ready1, s_ready0);
      if (prev_v && !prev_r) begin
        checkOutput("stall_valid", m_valid0, 1);
        checkOutput("stall_data0", m_data0, prev_d0);
        checkOutput("stall_data1", m_data1, prev_d1);
        checkOutput("stall_last", m_last0, prev_last);
      end
      if (m_valid0) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", m_valid0, 0);
        end else begin
          e = exp_q[0];
          checkOutput("data_tie0", m_data0, e.d0);
          checkOutput("data_tie1", m_data1, e.d1);
          checkOutput("last", m_last0, e.last);
          checkOutput("last_pair", m_last1, e.last);
          if (m_ready) begin
            void'(exp_q.pop_front());
            out_total++;
            if (m_last0) last_total++;
            if (m_data0 != 0) nz_total++;
          end
        end
      end
      prev_v = m_valid0; prev_r = m_ready; prev_d0 = m_data0; prev_d1 = m_data1; prev_last = m_last0;
      if (s_valid && s_ready0) begin
        if (s_sof) model_pos = 0;
        col  = model_pos % W;
        row  = model_pos / W;
        brd  = (col < 1) || (col >= W - 1) || (row < 1) || (row >= H - 1);
        dirv = int'(s_dir);
        e.d0 = nmsModel(s_mag, dirv, bypass, brd, 0);
        e.d1 = nmsModel(s_mag, dirv, bypass, brd, 1);
        e.last = (model_pos == FRAME - 1);
        exp_q.push_back(e);
        if ((dirv < 1 || dirv > 4) && model_cnt < CMAX) model_cnt++;
        model_pos = (model_pos + 1) % FRAME;
      end
    end
  end

  bit rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic applyStimulus(input logic [71:0] mag, input logic [7:0] dir, input logic sof);
    bit acc = 1'b0;
    int waited = 0;
    s_mag = mag; s_dir = dir; s_sof = sof; s_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = s_ready0 && rst_n;
      @(posedge clk); #1;
      if (!acc) begin
        waited++;
        if (waited > 200) begin
          checks++; errors++;
          $display("[TB] FAIL accept_timeout: got no accept expected accept within 200 cycles");
          acc = 1'b1;
        end
      end
    end
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin idle(1); n++; end
    checkOutput("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [71:0] setTap(input logic [71:0] w, input int idx, input logic [7:0] v);
    w[idx*8 +: 8] = v;
    return w;
  endfunction

  function automatic logic [71:0] randWin();
    logic [71:0] w;
    for (int t = 0; t < 9; t++) w[t*8 +: 8] = 8'($urandom_range(0, 4) * 60);
    return w;
  endfunction

  function automatic logic [7:0] randDir();
    int d = $urandom_range(0, 11);
    return 8'((d > 7) ? d - 7 : d);
  endfunction

  // One isolated beat with a literal expectation; output lands one clock after the accept edge.
  task automatic literalBeat(input string name, input logic [71:0] mag, input logic [7:0] dir,
                             input logic [7:0] e0, input logic [7:0] e1);
    idle(3);
    applyStimulus(mag, dir, 1'b0);
    checkOutput({name, "_early"}, m_valid0, 0);
    idle(1);
    checkOutput({name, "_valid"}, m_valid0, 1);
    checkOutput({name, "_tie0"}, m_data0, e0);
    checkOutput({name, "_tie1"}, m_data1, e1);
  endtask

  int nz_base, last_base, out_base;

  initial begin
    s_mag = '0; s_dir = 8'd1; s_sof = 1'b0; s_valid = 1'b0; bypass = 1'b0;
    rst_n = 1'b0;
    idle(3);
    checkOutput("rst_m_valid", m_valid0, 0);
    checkOutput("rst_m_data", m_data0, 0);
    checkOutput("rst_m_last", m_last0, 0);
    checkOutput("rst_cnt", cnt0, 0);
    checkOutput("rst_s_ready", s_ready0, 1);
    rst_n = 1'b1;
    idle(1);

    $display("[TB] directed beats");
    applyStimulus('0, 8'd1, 1'b1);
    for (int i = 1; i < 9; i++) applyStimulus('0, 8'd1, 1'b0);
    literalBeat("horz_20", setTap(setTap(setTap('0, 3, 10), 4, 20), 5, 15), 8'd1, 8'd20, 8'd20);
    literalBeat("vert_sup", setTap(setTap('0, 4, 20), 7, 21), 8'd3, 8'd0, 8'd0);
    literalBeat("diag_tie", setTap(setTap(setTap('0, 0, 20), 4, 20), 8, 20), 8'd2, 8'd20, 8'd0);
    literalBeat("dir0", setTap('0, 4, 50), 8'd0, 8'd0, 8'd0);
    literalBeat("dir7", setTap('0, 4, 50), 8'd7, 8'd0, 8'd0);
    checkOutput("cnt_after_illegal", cnt0, 2);
    bypass = 1'b1;
    literalBeat("byp_dir0", setTap('0, 4, 60), 8'd0, 8'd60, 8'd60);
    literalBeat("byp_border", setTap('0, 4, 90), 8'd1, 8'd0, 8'd0);
    applyStimulus('0, 8'd1, 1'b0);
    literalBeat("byp_dir7", setTap('0, 4, 70), 8'd7, 8'd70, 8'd70);
    checkOutput("cnt_after_bypass", cnt0, 4);
    idle(3);
    bypass = 1'b0;

    $display("[TB] full frame border");
    nz_base = nz_total; last_base = last_total; out_base = out_total;
    for (int i = 0; i < FRAME; i++) applyStimulus({9{8'hFF}}, 8'd1, 1'(i == 0));
    drain();
    checkOutput("frame_nonzero", nz_total - nz_base, 12);
    checkOutput("frame_lasts", last_total - last_base, 1);
    checkOutput("frame_beats", out_total - out_base, FRAME);

    $display("[TB] random backpressure");
    rand_ready = 1'b1;
    last_base = last_total; out_base = out_total;
    for (int f = 0; f < 3; f++) begin
      bypass = (f == 1);
      for (int i = 0; i < FRAME; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        applyStimulus(randWin(), randDir(), 1'(i == 0));
      end
      drain();
    end
    bypass = 1'b0;
    checkOutput("rand_lasts", last_total - last_base, 3);
    checkOutput("rand_beats", out_total - out_base, 3 * FRAME);

    $display("[TB] mid-frame sof and reset");
    last_base = last_total;
    for (int i = 0; i < 5; i++) applyStimulus(randWin(), randDir(), 1'(i == 0));
    for (int i = 0; i < FRAME; i++) applyStimulus(randWin(), randDir(), 1'(i == 0));
    drain();
    checkOutput("resync_lasts", last_total - last_base, 1);
    for (int i = 0; i < 10; i++) applyStimulus(randWin(), 8'(i % 8), 1'(i == 0));
    rst_n = 1'b0;
    idle(2);
    rand_ready = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checkOutput("post_rst_valid", m_valid0, 0);
      checkOutput("post_rst_cnt", cnt0, 0);
    end
    nz_base = nz_total;
    for (int i = 0; i < 10; i++) applyStimulus({9{8'hFF}}, 8'd1, 1'b0);
    drain();
    checkOutput("post_rst_nonzero", nz_total - nz_base, 1);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
